// File: rtl/barcode_reader.sv
// Bar-code receive path: deserialises a strobed bar/space cell stream into a
// DATA_WIDTH-bit student-number word, checks start/parity/stop framing and
// flags which known client the last good word belongs to.
//
// Input handshake: BitValid is a one-cycle strobe with no backpressure. Every
// cycle in which BitValid is high carries exactly one cell on BarIn, so
// holding BitValid high for N cycles delivers N cells.
module barcode_reader #(
  parameter int                    DATA_WIDTH = 45,
  parameter int                    TIMEOUT    = 1000,
  parameter logic [DATA_WIDTH-1:0] ID_A       = 45'd20460192049719,
  parameter logic [DATA_WIDTH-1:0] ID_B       = 45'd20497192046019
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  BarIn,
  input  logic                  BitValid,
  output logic [DATA_WIDTH-1:0] StudentNumbers,
  output logic                  ClientA,
  output logic                  ClientB,
  output logic                  FrameValid,
  output logic                  FrameError,
  output logic                  Busy,
  output logic [2:0]            state_dbg
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START1 = 3'd1,
    START2 = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         bit_cnt;
  logic [TW-1:0]         to_cnt;
  logic                  run_par;
  logic                  parity_ok;

  // Control strobes decoded by the next-state logic for the datapath.
  logic clr_data;
  logic shift_en;
  logic par_load;
  logic accept;
  logic reject;
  logic timeout_hit;

  // The counter would reach TIMEOUT on this edge; a strobe this cycle wins.
  assign timeout_hit = (to_cnt == TO_LAST) && !BitValid;

  assign Busy      = (state != IDLE);
  assign state_dbg = state;

  // State register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state and datapath control decode.
  always_comb begin
    next_state = state;
    clr_data   = 1'b0;
    shift_en   = 1'b0;
    par_load   = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: begin
        if (BitValid && BarIn) next_state = START1;
      end
      START1: begin
        // A repeated bar restarts the start pattern rather than failing it.
        if (BitValid) begin
          if (!BarIn) next_state = START2;
        end else if (timeout_hit) begin
          next_state = IDLE;
        end
      end
      START2: begin
        if (BitValid) begin
          if (BarIn) begin
            next_state = DATA;
            clr_data   = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end else if (timeout_hit) begin
          next_state = IDLE;
        end
      end
      DATA: begin
        if (BitValid) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) next_state = PARITY;
        end else if (timeout_hit) begin
          reject     = 1'b1;
          next_state = IDLE;
        end
      end
      PARITY: begin
        if (BitValid) begin
          par_load   = 1'b1;
          next_state = STOP;
        end else if (timeout_hit) begin
          reject     = 1'b1;
          next_state = IDLE;
        end
      end
      STOP: begin
        if (BitValid) begin
          next_state = IDLE;
          if (!BarIn && parity_ok) accept = 1'b1;
          else                     reject = 1'b1;
        end else if (timeout_hit) begin
          reject     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Inter-strobe watchdog: restarts on every cell and rests while idle.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)                          to_cnt <= '0;
    else if (state == IDLE || BitValid)   to_cnt <= '0;
    else                                  to_cnt <= to_cnt + 1'b1;
  end

  // Payload shift register, bit counter and running parity.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      run_par   <= 1'b0;
      parity_ok <= 1'b0;
    end else begin
      if (clr_data) begin
        bit_cnt <= '0;
        run_par <= 1'b0;
      end
      if (shift_en) begin
        shift_reg <= {shift_reg[DATA_WIDTH-2:0], BarIn};
        run_par   <= run_par ^ BarIn;
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (par_load) parity_ok <= ~(run_par ^ BarIn);
    end
  end

  // Registered results: only a good frame updates the word and client flags.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      StudentNumbers <= '0;
      ClientA        <= 1'b0;
      ClientB        <= 1'b0;
      FrameValid     <= 1'b0;
      FrameError     <= 1'b0;
    end else begin
      FrameValid <= accept;
      FrameError <= reject;
      if (accept) begin
        StudentNumbers <= shift_reg;
        ClientA        <= (shift_reg == ID_A);
        ClientB        <= (shift_reg == ID_B);
      end
    end
  end

endmodule

// File: tb/tb_barcode_reader.sv
// Directed bench for barcode_reader: framed words, parity/stop faults,
// start-pattern corner cases, watchdog boundary and asynchronous reset.
module tb_barcode_reader;

  localparam int W = 45;
  localparam int T = 1000;
  localparam int NBITS = W + 5;
  localparam logic [W-1:0] ID_A = 45'd20460192049719;
  localparam logic [W-1:0] ID_B = 45'd20497192046019;
  localparam logic [W-1:0] P_12345 = 45'd12345;

  logic         Clock = 1'b0;
  logic         ResetN = 1'b0;
  logic         BarIn = 1'b0;
  logic         BitValid = 1'b0;
  logic [W-1:0] StudentNumbers;
  logic         ClientA;
  logic         ClientB;
  logic         FrameValid;
  logic         FrameError;
  logic         Busy;
  logic [2:0]   state_dbg;

  int n_assert = 0;
  int n_fail = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  int fv0, fe0;
  logic frame_bits [NBITS];

  barcode_reader #(.DATA_WIDTH(W), .TIMEOUT(T), .ID_A(ID_A), .ID_B(ID_B)) dut (
    .Clock(Clock), .ResetN(ResetN), .BarIn(BarIn), .BitValid(BitValid),
    .StudentNumbers(StudentNumbers), .ClientA(ClientA), .ClientB(ClientB),
    .FrameValid(FrameValid), .FrameError(FrameError), .Busy(Busy),
    .state_dbg(state_dbg)
  );

  // Clock and pulse counters sampled away from the active edge.
  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (FrameValid) fv_cnt++;
    if (FrameError) fe_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start 1,0,1 + payload MSB first + even parity (optionally inverted) + stop.
  task automatic build_frame(input logic [W-1:0] p, input logic flip_par, input logic stop);
    frame_bits[0] = 1'b1;
    frame_bits[1] = 1'b0;
    frame_bits[2] = 1'b1;
    for (int i = 0; i < W; i++) frame_bits[3+i] = p[W-1-i];
    frame_bits[W+3] = (^p) ^ flip_par;
    frame_bits[W+4] = stop;
  endtask

  // Drive one strobe per cell, gap idle clocks between cells; returns at the
  // negedge following the edge that sampled the last cell.
  task automatic send_range(input int lo, input int hi, input int gap);
    for (int i = lo; i <= hi; i++) begin
      BarIn = frame_bits[i];
      BitValid = 1'b1;
      @(negedge Clock);
      BitValid = 1'b0;
      BarIn = 1'b0;
      if (i < hi) repeat (gap) @(negedge Clock);
    end
  endtask

  task automatic strobe(input logic b);
    BarIn = b;
    BitValid = 1'b1;
    @(negedge Clock);
    BitValid = 1'b0;
    BarIn = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge Clock);
    check("rst_sn", StudentNumbers, 0);
    check("rst_ca", ClientA, 0);
    check("rst_cb", ClientB, 0);
    check("rst_fv", FrameValid, 0);
    check("rst_fe", FrameError, 0);
    check("rst_busy", Busy, 0);
    check("rst_state", state_dbg, 0);
    ResetN = 1'b1;
    repeat (2) @(negedge Clock);

    // ID_A frame, one strobe every 4 clocks
    fv0 = fv_cnt; fe0 = fe_cnt;
    build_frame(ID_A, 1'b0, 1'b0);
    send_range(0, NBITS-1, 3);
    check("t1_fv", FrameValid, 1);
    check("t1_sn", StudentNumbers, ID_A);
    check("t1_ca", ClientA, 1);
    check("t1_cb", ClientB, 0);
    @(negedge Clock);
    check("t1_fv_drop", FrameValid, 0);
    check("t1_busy", Busy, 0);
    repeat (2) @(negedge Clock);
    check("t1_fv_count", fv_cnt - fv0, 1);
    check("t1_fe_count", fe_cnt - fe0, 0);

    // ID_B frame with BitValid held high throughout
    build_frame(ID_B, 1'b0, 1'b0);
    send_range(0, NBITS-2, 0);
    BarIn = frame_bits[NBITS-1];
    BitValid = 1'b1;
    check("t2_fv_early", FrameValid, 0);
    check("t2_busy", Busy, 1);
    @(negedge Clock);
    BitValid = 1'b0;
    BarIn = 1'b0;
    check("t2_fv", FrameValid, 1);
    check("t2_sn", StudentNumbers, ID_B);
    check("t2_ca", ClientA, 0);
    check("t2_cb", ClientB, 1);
    @(negedge Clock);
    check("t2_fv_drop", FrameValid, 0);
    repeat (2) @(negedge Clock);

    // Good ID_A, then ID_B with inverted parity
    build_frame(ID_A, 1'b0, 1'b0);
    send_range(0, NBITS-1, 1);
    check("t3_fv", FrameValid, 1);
    repeat (2) @(negedge Clock);
    build_frame(ID_B, 1'b1, 1'b0);
    send_range(0, NBITS-1, 1);
    check("t3_fe", FrameError, 1);
    check("t3_fv", FrameValid, 0);
    check("t3_sn", StudentNumbers, ID_A);
    check("t3_ca", ClientA, 1);
    check("t3_cb", ClientB, 0);
    @(negedge Clock);
    check("t3_fe_drop", FrameError, 0);
    repeat (2) @(negedge Clock);

    // 12345 with bad stop bit, then a good 12345 frame (unknown client)
    build_frame(P_12345, 1'b0, 1'b1);
    send_range(0, NBITS-1, 2);
    check("t4_fe", FrameError, 1);
    check("t4_sn_keep", StudentNumbers, ID_A);
    check("t4_ca_keep", ClientA, 1);
    repeat (2) @(negedge Clock);
    build_frame(P_12345, 1'b0, 1'b0);
    send_range(0, NBITS-1, 2);
    check("t4_fv", FrameValid, 1);
    check("t4_sn", StudentNumbers, P_12345);
    check("t4_ca", ClientA, 0);
    check("t4_cb", ClientB, 0);
    repeat (2) @(negedge Clock);

    // Start sequence 1,1,0,0: back to idle silently
    fv0 = fv_cnt; fe0 = fe_cnt;
    strobe(1'b1);
    strobe(1'b1);
    check("t5_start1", state_dbg, 1);
    strobe(1'b0);
    check("t5_start2_busy", Busy, 1);
    strobe(1'b0);
    check("t5_idle_busy", Busy, 0);
    repeat (5) @(negedge Clock);
    check("t5_no_fv", fv_cnt - fv0, 0);
    check("t5_no_fe", fe_cnt - fe0, 0);

    // Stall of TIMEOUT clocks after 20 data bits
    build_frame(ID_B, 1'b0, 1'b0);
    send_range(0, 22, 0);
    repeat (T-1) @(negedge Clock);
    check("t5_to_early_fe", FrameError, 0);
    check("t5_to_early_busy", Busy, 1);
    @(negedge Clock);
    check("t5_to_fe", FrameError, 1);
    check("t5_to_busy", Busy, 0);
    check("t5_to_sn_keep", StudentNumbers, P_12345);
    @(negedge Clock);
    check("t5_to_fe_drop", FrameError, 0);
    repeat (2) @(negedge Clock);

    // Strobe lands in the cycle the watchdog would expire: frame continues
    fe0 = fe_cnt;
    send_range(0, 22, 0);
    repeat (T-1) @(negedge Clock);
    check("t5_late_busy", Busy, 1);
    send_range(23, NBITS-1, 0);
    check("t5_late_fv", FrameValid, 1);
    check("t5_late_sn", StudentNumbers, ID_B);
    check("t5_late_cb", ClientB, 1);
    repeat (2) @(negedge Clock);
    check("t5_late_no_fe", fe_cnt - fe0, 0);

    // Asynchronous reset mid-DATA
    build_frame(ID_A, 1'b0, 1'b0);
    send_range(0, 12, 1);
    #2 ResetN = 1'b0;
    #1;
    check("t6_sn", StudentNumbers, 0);
    check("t6_cb", ClientB, 0);
    check("t6_ca", ClientA, 0);
    check("t6_fv", FrameValid, 0);
    check("t6_fe", FrameError, 0);
    check("t6_busy", Busy, 0);
    @(negedge Clock);
    ResetN = 1'b1;
    @(negedge Clock);
    fe0 = fe_cnt;
    send_range(0, NBITS-1, 2);
    check("t6_fv", FrameValid, 1);
    check("t6_sn_after", StudentNumbers, ID_A);
    check("t6_ca_after", ClientA, 1);
    check("t6_cb_after", ClientB, 0);
    repeat (2) @(negedge Clock);
    check("t6_no_fe", fe_cnt - fe0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/barcode_reader.md
Name: barcode_reader

Overview:
- Receive side of the bar-code path: deserialises a scanned bar stream back into the 45-bit concatenated student-number word.
- Checks framing and parity, then reports which client the scanned code belongs to.
- Sits between the scanner front-end (one strobed bar/space bit per scan cell) and the display/compare logic that consumes StudentNumbers, ClientA and ClientB.

Parameters:
- DATA_WIDTH, 45, payload bits per frame.
- TIMEOUT, 1000, max clock cycles between BitValid strobes inside a frame before abort.
- ID_A, 45'd20460192049719, word identifying client A.
- ID_B, 45'd20497192046019, word identifying client B.

Ports:
- Clock  in  1  system clock, rising edge.
- ResetN  in  1  asynchronous active-low reset.
- BarIn  in  1  scanned cell value, 1 = bar, 0 = space; sampled only when BitValid=1.
- BitValid  in  1  one-cycle strobe, one per scanned cell.
- StudentNumbers  out  45  last correctly received payload.
- ClientA  out  1  last good payload == ID_A.
- ClientB  out  1  last good payload == ID_B.
- FrameValid  out  1  one-cycle pulse: good frame accepted.
- FrameError  out  1  one-cycle pulse: frame rejected.
- Busy  out  1  FSM not in IDLE.

Behaviour:
- Reset is asynchronous and active-low on ResetN, with a single clock domain (Clock).
- ResetN=0 forces:
  - StudentNumbers=0, ClientA=0, ClientB=0, FrameValid=0, FrameError=0, Busy=0.
  - FSM to IDLE; shift register, bit counter and timeout counter all to 0.
- Frame on BitValid strobes, in order:
  - Start pattern 1,0,1.
  - DATA_WIDTH payload bits, MSB first.
  - 1 even-parity bit: total ones over payload+parity is even.
  - 1 stop bit = 0.
- FSM states: IDLE, START1, START2, DATA, PARITY, STOP.
- IDLE:
  - Strobe with BarIn=1 -> START1.
  - BarIn=0 ignored.
- START1:
  - Strobe with 0 -> START2.
  - Strobe with 1 -> stay START1; a repeated bar is treated as a new first start bit.
- START2:
  - Strobe with 1 -> DATA; clear bit counter and running parity.
  - Strobe with 0 -> IDLE, no error.
- DATA:
  - Each strobe: shift BarIn into the LSB of the shift register; XOR BarIn into running parity; increment counter.
  - On the strobe where counter == DATA_WIDTH-1 -> PARITY.
- PARITY:
  - Strobe: parity_ok = (running parity XOR BarIn) == 0; register parity_ok -> STOP.
- STOP, on strobe:
  - If BarIn=0 and parity_ok: on the next edge load StudentNumbers from the shift register.
  - Same edge: ClientA=(shift==ID_A), ClientB=(shift==ID_B).
  - Same edge: pulse FrameValid for 1 cycle; go to IDLE.
  - Otherwise: pulse FrameError for 1 cycle; StudentNumbers/ClientA/ClientB keep their previous values; go to IDLE.
- Latency: FrameValid/FrameError are high in the cycle immediately after the edge that samples the stop-bit strobe.
  - Outputs are registered; there is no combinational path from BarIn.
- ClientA and ClientB are never both 1.
  - Neither set together with FrameValid means an unknown code; it is still a valid frame.
- Timeout counter:
  - Cleared on every strobe and while in IDLE; increments each cycle otherwise.
  - On reaching TIMEOUT in START1/START2 -> IDLE silently.
  - On reaching TIMEOUT in DATA/PARITY/STOP -> FrameError pulse, IDLE.
  - A strobe in the same cycle the counter reaches TIMEOUT wins: it is processed normally and there is no timeout.
- BitValid held high for consecutive cycles counts one bit per cycle.
- Busy=1 in every state except IDLE.
- Reset mid-frame: immediate abort, all outputs to reset values, no error pulse.

Test Plan:
- Reset, then a full frame carrying 20460192049719 with correct parity and stop=0, one strobe every 4 clocks -> FrameValid pulse 1 cycle after the stop strobe; StudentNumbers=20460192049719, ClientA=1, ClientB=0, FrameError never high.
- Same frame for 20497192046019 with BitValid held continuously high -> StudentNumbers=20497192046019, ClientA=0, ClientB=1; FrameValid exactly 50 cycles after the first start strobe's edge plus 1.
- Good frame for ID_A, then a frame for ID_B with the parity bit inverted -> FrameError pulse; StudentNumbers stays 20460192049719, ClientA=1.
- Good payload 12345 with stop bit = 1 -> FrameError; outputs unchanged. Then good frame 12345 -> FrameValid, ClientA=0, ClientB=0.
- Start sequence 1,1,0,0 followed by idle -> no pulses, Busy returns 0. Then a stall of TIMEOUT clocks after 20 data bits -> FrameError at exactly TIMEOUT cycles; a strobe arriving at cycle TIMEOUT-1 continues the frame without error.
- ResetN driven low asynchronously mid-DATA (between clock edges) -> all outputs 0 immediately, Busy=0. After release, a fresh good ID_A frame decodes correctly.
